// File: rtl/io_uart_responder.sv
// IO-bus responder: LED register plus a buffered 8N1 UART transmitter.
// Decodes the processor's IO_mem_* bus and returns combinational read data.
module io_uart_responder #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IO_mem_addr,
    input  logic [31:0] IO_mem_wdata,
    input  logic        IO_mem_wr,
    output logic [31:0] IO_mem_rdata,
    output logic [4:0]  leds,
    output logic        uart_txd
);

    localparam int DIV  = CLK_FREQ_HZ / BAUD;
    localparam int CW   = $clog2(DIV);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam logic [CW-1:0]   BAUD_RELOAD = CW'(DIV - 1);
    localparam logic [CNTW-1:0] DEPTH_CNT   = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    logic            sel_led, sel_dat, sel_cntl;
    logic            dat_wr, cntl_wr, led_wr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            fifo_empty, fifo_full, push, pop;
    logic            overflow, busy;
    tx_state_t       state, state_d;
    logic [CW-1:0]   baud_cnt, baud_d;
    logic [2:0]      bit_cnt, bit_d;
    logic [7:0]      shift, shift_d;
    logic [8:0]      count_ext;
    logic            unused_bits;

    // Word-index bits are one-hot selects; several may be set at once.
    assign sel_led  = IO_mem_addr[22] & IO_mem_addr[2];
    assign sel_dat  = IO_mem_addr[22] & IO_mem_addr[3];
    assign sel_cntl = IO_mem_addr[22] & IO_mem_addr[4];
    assign led_wr   = IO_mem_wr & sel_led;
    assign dat_wr   = IO_mem_wr & sel_dat;
    assign cntl_wr  = IO_mem_wr & sel_cntl;

    // FIFO handshake: push valid = dat_wr, ready = !fifo_full (pre-edge count);
    // pop valid = !fifo_empty, ready = serialiser requesting a byte.
    // A transfer happens on the edge where valid and ready are both high.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign push       = dat_wr & ~fifo_full;
    assign busy       = ~fifo_empty | (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= IO_mem_wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            leds     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Clear wins over a same-cycle drop.
            if (cntl_wr)                  overflow <= 1'b0;
            else if (dat_wr && fifo_full) overflow <= 1'b1;
            if (led_wr) leds <= IO_mem_wdata[4:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
        end
    end

    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    baud_d  = BAUD_RELOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_cnt == '0) begin
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (baud_cnt == '0) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) state_d = S_STOP;
                    else                 bit_d   = bit_cnt + 3'd1;
                end else begin
                    baud_d = baud_cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (baud_cnt == '0) begin
                    // Next byte goes straight to START so frames abut.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        baud_d  = BAUD_RELOAD;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_cnt - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            S_START: uart_txd = 1'b0;
            S_DATA:  uart_txd = shift[0];
            default: uart_txd = 1'b1;
        endcase
    end

    assign count_ext = 9'(count);

    always_comb begin
        IO_mem_rdata = '0;
        if (sel_led)  IO_mem_rdata = IO_mem_rdata | {27'b0, leds};
        if (sel_cntl) IO_mem_rdata = IO_mem_rdata |
                                     {16'b0, count_ext[7:0], 5'b0, overflow, fifo_full, busy};
    end

    assign unused_bits = ^{IO_mem_addr[31:23], IO_mem_addr[21:5], IO_mem_addr[1:0],
                           IO_mem_wdata[31:8], count_ext[8]};

endmodule

// File: doc/io_uart_responder.md
Name: io_uart_responder

Overview:
Responder side of the processor's memory-mapped IO bus. It decodes the processor's IO address, write-data and write-strobe signals and drives combinational read data back. It implements an LED output register and a buffered UART transmitter: a TX FIFO feeding an 8N1 serialiser. It sits beside the processor at top level and connects directly to the IO_mem_* ports.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; DIV = CLK_FREQ_HZ/BAUD (integer truncation), DIV >= 2
FIFO_DEPTH, 16, TX FIFO entries; power of 2, 2..256

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
IO_mem_addr  input  32  byte address from processor; bit 22 = IO space select
IO_mem_wdata  input  32  write data
IO_mem_wr  input  1  single-cycle write strobe, already qualified by processor
IO_mem_rdata  output  32  read data, combinational from IO_mem_addr and registered state
leds  output  5  LED register
uart_txd  output  1  serial output, idle high

Behaviour:
- Address decode is one-hot on word index IO_mem_addr[13:2] and is valid only when IO_mem_addr[22]=1:
  - bit0 (addr 0x400004): LEDS
  - bit1 (0x400008): UART_DAT
  - bit2 (0x400010): UART_CNTL
- Multiple bits set: all selected registers are written; read data is the OR of the selected read values.
- Reset (async, any time, including mid-frame):
  - leds=0, uart_txd=1 immediately, FIFO emptied (count=0, pointers=0), overflow=0, serialiser IDLE.
- LEDS:
  - write sets leds <= wdata[4:0] at the write edge.
  - read returns {27'b0, leds}.
- UART_DAT write:
  - if count < FIFO_DEPTH before the edge, wdata[7:0] is pushed and count increments.
  - otherwise the byte is dropped and sticky overflow <= 1.
  - Acceptance is judged on pre-edge count; a pop in the same cycle does not rescue a full-FIFO write.
  - Read of UART_DAT returns 0.
- UART_CNTL:
  - read returns {16'b0, count[7:0] zero-extended into bits 15:8, 5'b0, overflow(bit2), full(bit1), busy(bit0)}.
  - busy = FIFO non-empty OR serialiser not IDLE; full = (count==FIFO_DEPTH).
  - Any write clears overflow (a clear wins over a same-cycle overflow set).
- Serialiser FSM: IDLE -> START -> DATA -> STOP -> IDLE, or STOP -> START if FIFO non-empty.
  - IDLE: txd=1. If FIFO non-empty, pop the head into the shift register and enter START.
  - START: txd=0 for DIV cycles.
  - DATA: 8 bits LSB first, DIV cycles each, 3-bit bit counter.
  - STOP: txd=1 for DIV cycles. At the end, pop the next byte directly to START if available (back-to-back frames, no idle gap).
  - Frame = 10*DIV cycles.
  - Baud counter counts DIV-1 down to 0 and reloads on each bit transition.
- Latency: byte written at edge N with the serialiser idle -> popped at edge N+1, uart_txd low after edge N+1.
- Simultaneous push and pop: both occur, count unchanged. Push when empty with the serialiser idle is popped the next cycle (no same-cycle bypass).
- Count width is clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
- IO_mem_rdata has no state effect; reads have no side effects.
- IO_mem_wr with IO_mem_addr[22]=0 is ignored.

Test Plan:
- Reset value check:
  - Stimulus: assert reset mid-frame (CLK_FREQ_HZ=1000000, BAUD=100000, DIV=10).
  - Required: uart_txd=1 without waiting for a clock edge; leds=0; CNTL read = 0x00000000.
- LED register:
  - Stimulus: write 0x400004 with 0xFFFFFF15.
  - Required: leds=5'h15 after the edge; read 0x400004 returns 0x00000015.
- Single frame:
  - Stimulus: write 0x400008 with 0xA5.
  - Required: start bit low for 10 cycles beginning one cycle after the write; then bits 1,0,1,0,0,1,0,1, 10 cycles each; stop bit high; busy=1 throughout, 0 after stop.
- Back-to-back:
  - Stimulus: write 0x41, 0x42, 0x43 on consecutive cycles.
  - Required: three contiguous frames, 300 cycles total, no idle between stop and next start; CNTL count reads 2, then 1, then 0.
- Overflow:
  - Stimulus: FIFO_DEPTH=4; write 6 bytes in 6 cycles.
  - Required: after the writes, CNTL bit1 (full) is 1; bit2=1; 0x400010 read returns 0x407 (count=4, overflow, full, busy), since the first byte was popped at cycle 2 and its slot refilled. The 6th byte is dropped; 5 frames are sent.
  - Then: a CNTL write clears bit2.
- Non-IO address:
  - Stimulus: write addr 0x000008 with IO_mem_wr=1.
  - Required: FIFO count stays 0, uart_txd stays 1.
